// File: rtl/reg_pkg.sv
// Shared defaults for the register writeback arbiter: source map and widths.
package reg_pkg;

  localparam int NUM_SRC    = 3;
  localparam int SRC_ALU    = 0;
  localparam int SRC_MEM    = 1;
  localparam int SRC_MULDIV = 2;
  localparam int ADDR_W     = 5;
  localparam int DATA_W     = 32;

  // Pointer width that stays legal for a single-source configuration.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin selector: one-hot grant to the first requester after the pointer.
module rr_arb #(
  parameter int N     = 3,
  parameter int PTR_W = reg_pkg::ptr_width(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o
);

  int   idx;
  logic found;

  // Search order is ptr+1, ptr+2, ... wrapping, ending at ptr itself.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(ptr_i) + i) % N;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_wb_arb.sv
// Writeback arbiter: round-robin among result sources into one register-file
// write port, plus a per-register pending-write scoreboard.
module reg_wb_arb #(
  parameter int NUM_SRC = reg_pkg::NUM_SRC,
  parameter int DATA_W  = reg_pkg::DATA_W,
  parameter int ADDR_W  = reg_pkg::ADDR_W
) (
  input  logic                      clk,
  input  logic                      SYS_reset_n,
  input  logic [NUM_SRC-1:0]        WBA_req,
  input  logic [NUM_SRC*ADDR_W-1:0] WBA_addr,
  input  logic [NUM_SRC*DATA_W-1:0] WBA_data,
  output logic [NUM_SRC-1:0]        WBA_gnt,
  input  logic                      WBA_rsv_valid,
  input  logic [ADDR_W-1:0]         WBA_rsv_addr,
  output logic [(1<<ADDR_W)-1:0]    WBA_busy,
  output logic                      REG_write_1,
  output logic [ADDR_W-1:0]         REG_address_wr,
  output logic [DATA_W-1:0]         REG_data_wb_in1
);

  import reg_pkg::*;

  localparam int PTR_W = ptr_width(NUM_SRC);
  localparam int NREG  = 1 << ADDR_W;

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_SRC-1:0] arb_gnt;
  logic               acc;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic [PTR_W-1:0]   sel_idx;
  logic [NREG-1:0]    busy_q, busy_d;
  logic               wr_q, wr_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;

  rr_arb #(.N(NUM_SRC), .PTR_W(PTR_W)) u_rr_arb (
    .req_i (WBA_req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt)
  );

  // Grants are gated by reset so nothing is accepted while held in reset.
  assign WBA_gnt = arb_gnt & {NUM_SRC{SYS_reset_n}};

  always_comb begin
    acc      = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    sel_idx  = ptr_q;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (WBA_gnt[k]) begin
        acc      = 1'b1;
        sel_addr = WBA_addr[k*ADDR_W +: ADDR_W];
        sel_data = WBA_data[k*DATA_W +: DATA_W];
        sel_idx  = PTR_W'(k);
      end
    end
  end

  // Register 0 is hardwired: its writes are accepted but never issued.
  // Reservation is applied after the clear so a same-cycle reserve wins.
  always_comb begin
    ptr_d   = sel_idx;
    wr_d    = acc && (sel_addr != '0);
    waddr_d = acc ? sel_addr : waddr_q;
    wdata_d = acc ? sel_data : wdata_q;
    busy_d  = busy_q;
    if (acc) busy_d[sel_addr] = 1'b0;
    if (WBA_rsv_valid) busy_d[WBA_rsv_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      ptr_q   <= PTR_W'(NUM_SRC - 1);
      wr_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      wr_q    <= wr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign REG_write_1     = wr_q;
  assign REG_address_wr  = waddr_q;
  assign REG_data_wb_in1 = wdata_q;
  assign WBA_busy        = busy_q;

endmodule
